// File: rtl/zld_xc_dec.sv
// Zero run-length decoder: expands run tokens back into zero samples, passes literals through.
// Optional macro ZLD_ERR_EN enables the sticky o_err flag for zero-length run tokens.
module zld_xc_dec #(
  parameter int DW = 3,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CW:0]   i_d,
  input  logic          i_v,
  output logic          i_b,
  output logic [DW-1:0] o_d,
  output logic          o_v,
  input  logic          o_b,
  output logic          o_err,
  output logic          dbg_state
);

  typedef enum logic {S_START = 1'b0, S_ZEROS = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [DW-1:0] o_d_q, o_d_d;
  logic          o_v_q, o_v_d;
  logic          err_q, err_d;

  logic          free;
  logic          take;
  logic [CW-1:0] run_n;

  // Handshake: a token moves when i_v && !i_b; a sample moves when o_v && !o_b.
  assign free  = !o_v_q || !o_b;
  assign i_b   = (state_q == S_ZEROS) || !free;
  assign take  = i_v && !i_b;
  assign run_n = i_d[CW-1:0];

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    o_d_d   = o_d_q;
    o_v_d   = o_v_q;
    err_d   = err_q;
    if (state_q == S_START) begin
      if (take) begin
        if (i_d[CW]) begin
          if (run_n == '0) begin
            o_v_d = 1'b0;
            err_d = 1'b1;
          end else begin
            o_d_d = '0;
            o_v_d = 1'b1;
            if (run_n >= CW'(2)) begin
              rem_d   = run_n - CW'(1);
              state_d = S_ZEROS;
            end
          end
        end else begin
          o_d_d = i_d[DW-1:0];
          o_v_d = 1'b1;
        end
      end else if (free) begin
        o_v_d = 1'b0;
      end
    end else if (free) begin
      o_d_d = '0;
      o_v_d = 1'b1;
      // rem is always >= 1 here; the guard keeps it from ever wrapping.
      if (rem_q != '0) rem_d = rem_q - CW'(1);
      if (rem_q <= CW'(1)) state_d = S_START;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_START;
      rem_q   <= '0;
      o_d_q   <= '0;
      o_v_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      o_d_q   <= o_d_d;
      o_v_q   <= o_v_d;
      err_q   <= err_d;
    end
  end

  assign o_d       = o_d_q;
  assign o_v       = o_v_q;
  assign dbg_state = state_q;

`ifdef ZLD_ERR_EN
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_zld_xc_dec.sv
// Directed bench for zld_xc_dec (DW=3, CW=4) with hand-computed expectations.
module tb_zld_xc_dec;

  logic       clock;
  logic       reset;
  logic [4:0] i_d;
  logic       i_v;
  logic       i_b;
  logic [2:0] o_d;
  logic       o_v;
  logic       o_b;
  logic       o_err;
  logic       dbg_state;

  int total = 0;
  int bad   = 0;
  int taken = 0;

`ifdef ZLD_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  zld_xc_dec #(.DW(3), .CW(4)) dut (
    .clock(clock), .reset(reset), .i_d(i_d), .i_v(i_v), .i_b(i_b),
    .o_d(o_d), .o_v(o_v), .o_b(o_b), .o_err(o_err), .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; a sample counts as delivered if o_v && !o_b there.
  task automatic drive(input logic v, input logic [4:0] d, input logic ob);
    @(negedge clock);
    i_v = v;
    i_d = d;
    o_b = ob;
    #1;
    if (o_v && !o_b) taken++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input int d);
    check({tag, "_ov"}, int'(o_v), int'(v));
    if (v) check({tag, "_od"}, int'(o_d), d);
  endtask

  initial begin
    reset = 1'b1; i_v = 1'b0; i_d = '0; o_b = 1'b0;
    tick(); tick();
    check("rst_ov", int'(o_v), 0);
    check("rst_od", int'(o_d), 0);
    check("rst_err", int'(o_err), 0);
    check("rst_state", int'(dbg_state), 0);
    drive(1'b0, 5'b0_0000, 1'b0);
    reset = 1'b0;
    check("rst_ib", int'(i_b), 0);
    tick();

    // T1: two literals back to back
    drive(1'b1, 5'b0_0101, 1'b0); check("t1_ib0", int'(i_b), 0); tick();
    expect_out("t1_a", 1'b1, 5);
    drive(1'b1, 5'b0_0011, 1'b0); check("t1_ib1", int'(i_b), 0); tick();
    expect_out("t1_b", 1'b1, 3);
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    expect_out("t1_idle", 1'b0, 0);

    // T2: run of 3 then literal 7
    drive(1'b1, 5'b1_0011, 1'b0); check("t2_ib_run", int'(i_b), 0); tick();
    expect_out("t2_z0", 1'b1, 0);
    check("t2_state", int'(dbg_state), 1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 5'b0_0111, 1'b0); check($sformatf("t2_stall%0d", k), int'(i_b), 1); tick();
      expect_out($sformatf("t2_z%0d", k + 1), 1'b1, 0);
    end
    drive(1'b1, 5'b0_0111, 1'b0); check("t2_ib_lit", int'(i_b), 0); tick();
    expect_out("t2_lit", 1'b1, 7);
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    expect_out("t2_idle", 1'b0, 0);

    // T3: maximum run of 15
    drive(1'b1, 5'b1_1111, 1'b0); tick();
    expect_out("t3_z0", 1'b1, 0);
    for (int k = 1; k < 15; k++) begin
      drive(1'b1, 5'b0_0001, 1'b0); check($sformatf("t3_ib%0d", k), int'(i_b), 1); tick();
      expect_out($sformatf("t3_z%0d", k), 1'b1, 0);
    end
    check("t3_state_end", int'(dbg_state), 0);
    drive(1'b1, 5'b0_0001, 1'b0); check("t3_ib16", int'(i_b), 0); tick();
    expect_out("t3_lit", 1'b1, 1);
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    expect_out("t3_idle", 1'b0, 0);

    // T4: run of 4 with a 3-cycle output stall after the 2nd zero
    taken = 0;
    drive(1'b1, 5'b1_0100, 1'b0); tick();
    expect_out("t4_z0", 1'b1, 0);
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    expect_out("t4_z1", 1'b1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'b0_0110, 1'b1); check($sformatf("t4_ib_hold%0d", k), int'(i_b), 1); tick();
      expect_out($sformatf("t4_hold%0d", k), 1'b1, 0);
      check($sformatf("t4_state_hold%0d", k), int'(dbg_state), 1);
    end
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    expect_out("t4_z2", 1'b1, 0);
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    expect_out("t4_z3", 1'b1, 0);
    check("t4_state_end", int'(dbg_state), 0);
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    expect_out("t4_idle", 1'b0, 0);
    drive(1'b0, 5'b0_0000, 1'b0);
    check("t4_taken", taken, 4);

    // T5: zero-length run token is consumed and dropped
    drive(1'b1, 5'b1_0000, 1'b0); check("t5_ib", int'(i_b), 0); tick();
    expect_out("t5_none", 1'b0, 0);
    check("t5_state", int'(dbg_state), 0);
    check("t5_err", int'(o_err), int'(ERR_EXP));
    drive(1'b1, 5'b0_0010, 1'b0); tick();
    expect_out("t5_lit", 1'b1, 2);
    check("t5_err_sticky", int'(o_err), int'(ERR_EXP));

    // T6: reset in the middle of a run of 10
    drive(1'b1, 5'b1_1010, 1'b0); tick();
    expect_out("t6_z0", 1'b1, 0);
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    expect_out("t6_z2", 1'b1, 0);
    drive(1'b0, 5'b0_0000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_ov", int'(o_v), 0);
    check("t6_state", int'(dbg_state), 0);
    check("t6_err", int'(o_err), 0);
    drive(1'b1, 5'b0_0110, 1'b0); check("t6_ib", int'(i_b), 0); tick();
    expect_out("t6_lit", 1'b1, 6);

    // Output stall in S_START holds the token; literal zero passes through
    drive(1'b1, 5'b0_0101, 1'b1); check("bp_ib", int'(i_b), 1); tick();
    expect_out("bp_hold", 1'b1, 6);
    drive(1'b1, 5'b0_0101, 1'b0); check("bp_ib_rel", int'(i_b), 0); tick();
    expect_out("bp_lit", 1'b1, 5);
    drive(1'b1, 5'b0_0000, 1'b0); tick();
    expect_out("lit0", 1'b1, 0);
    check("lit0_state", int'(dbg_state), 0);
    drive(1'b1, 5'b1_0001, 1'b0); tick();
    expect_out("run1", 1'b1, 0);
    check("run1_state", int'(dbg_state), 0);
    drive(1'b0, 5'b0_0000, 1'b0); tick();
    expect_out("final_idle", 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
